// File: rtl/fpu_addsub_if.sv
// rtl/fpu_addsub_if.sv - start/done handshake and operand/result bundle for fpu_addsub
interface fpu_addsub_if #(
  parameter int W = 32
);
  logic         start;
  logic         op;
  logic [W-1:0] op_A_in;
  logic [W-1:0] op_B_in;
  logic         busy;
  logic         done;
  logic [W-1:0] data_out;
  logic [3:0]   status_out;

  modport master (
    output start, op, op_A_in, op_B_in,
    input  busy, done, data_out, status_out
  );

  modport slave (
    input  start, op, op_A_in, op_B_in,
    output busy, done, data_out, status_out
  );
endinterface

// File: rtl/fpu_addsub.sv
// rtl/fpu_addsub.sv - multi-cycle sign/exp/frac adder-subtractor, 4 cycles start to done
// FPU_RNE_EN defined: round-to-nearest-even; undefined: truncation toward zero.
module fpu_addsub #(
  parameter int EXP_W = 6,
  parameter int MAN_W = 25
) (
  input  logic        clock,
  input  logic        reset,
  fpu_addsub_if.slave fpu_io
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int MW  = MAN_W + 4;
  localparam int EW  = EXP_W + 2;
  localparam int LZW = $clog2(MW + 1);
  localparam logic signed [EW-1:0] EXP_TOP = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ONE = EW'(1);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND} state_t;

  state_t               state_q;
  logic                 l_sign_q, sub_q, res_sign_q, busy_q, done_q;
  logic [EXP_W-1:0]     l_exp_q, exp_diff_q;
  logic [MW-1:0]        l_man_q, s_man_q, norm_man_q;
  logic [MW:0]          sum_q;
  logic signed [EW-1:0] norm_exp_q;
  logic [W-1:0]         data_q;
  logic [3:0]           status_q;

  logic                 l_sign_d, sub_d, res_sign_d;
  logic [EXP_W-1:0]     l_exp_d, exp_diff_d;
  logic [MW-1:0]        l_man_d, s_man_d, align_d, norm_man_d;
  logic [MW:0]          sum_d;
  logic signed [EW-1:0] norm_exp_d;
  logic [W-1:0]         data_d;
  logic [3:0]           status_d;

  logic [EXP_W-1:0]     a_exp, b_exp;
  logic [MAN_W-1:0]     a_frac, b_frac;
  logic                 a_sign, b_sign;
  logic [2*MW-1:0]      s_ext;
  logic [LZW-1:0]       lzc;
  logic                 found;
  logic [MAN_W+1:0]     rnd_man;
  logic [MAN_W-1:0]     fin_frac;
  logic signed [EW-1:0] fin_exp;
  logic                 round_up, inexact;

  // Zero exponent flushes the operand to zero, so its fraction is masked before ordering.
  always_comb begin
    a_sign = fpu_io.op_A_in[W-1];
    b_sign = fpu_io.op_B_in[W-1] ^ fpu_io.op;
    a_exp  = fpu_io.op_A_in[W-2 -: EXP_W];
    b_exp  = fpu_io.op_B_in[W-2 -: EXP_W];
    a_frac = (a_exp != '0) ? fpu_io.op_A_in[MAN_W-1:0] : '0;
    b_frac = (b_exp != '0) ? fpu_io.op_B_in[MAN_W-1:0] : '0;
    sub_d  = a_sign ^ b_sign;
    if ({a_exp, a_frac} >= {b_exp, b_frac}) begin
      l_sign_d   = a_sign;
      l_exp_d    = a_exp;
      l_man_d    = {|a_exp, a_frac, 3'b000};
      s_man_d    = {|b_exp, b_frac, 3'b000};
      exp_diff_d = a_exp - b_exp;
    end else begin
      l_sign_d   = b_sign;
      l_exp_d    = b_exp;
      l_man_d    = {|b_exp, b_frac, 3'b000};
      s_man_d    = {|a_exp, a_frac, 3'b000};
      exp_diff_d = b_exp - a_exp;
    end
  end

  // Shifts of MW-1 or more leave only the sticky bit, which falls out of the same expression.
  always_comb begin
    s_ext   = {s_man_q, {MW{1'b0}}} >> exp_diff_q;
    align_d = s_ext[2*MW-1:MW] | {{(MW-1){1'b0}}, |s_ext[MW-1:0]};
  end

  always_comb begin
    sum_d      = sub_q ? ({1'b0, l_man_q} - {1'b0, s_man_q})
                       : ({1'b0, l_man_q} + {1'b0, s_man_q});
    res_sign_d = (sum_d != '0) & l_sign_q;
  end

  always_comb begin
    lzc   = '0;
    found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!found) begin
        if (sum_q[i]) found = 1'b1;
        else          lzc   = lzc + LZW'(1);
      end
    end
    if (sum_q[MW]) begin
      norm_man_d = {sum_q[MW:2], |sum_q[1:0]};
      norm_exp_d = {2'b00, l_exp_q} + EW'(1);
    end else begin
      norm_man_d = sum_q[MW-1:0] << lzc;
      norm_exp_d = {2'b00, l_exp_q} - {{(EW-LZW){1'b0}}, lzc};
    end
  end

  // norm_man_q holds {hidden, frac, G, R, S}.
  always_comb begin
    inexact = |norm_man_q[2:0];
`ifdef FPU_RNE_EN
    round_up = norm_man_q[2] & (norm_man_q[1] | norm_man_q[0] | norm_man_q[3]);
`else
    round_up = 1'b0;
`endif
    rnd_man = {1'b0, norm_man_q[MW-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
    if (rnd_man[MAN_W+1]) begin
      fin_frac = rnd_man[MAN_W:1];
      fin_exp  = norm_exp_q + EW'(1);
    end else begin
      fin_frac = rnd_man[MAN_W-1:0];
      fin_exp  = norm_exp_q;
    end
    if (norm_man_q == '0) begin
      data_d   = '0;
      status_d = 4'b0001;
    end else if (fin_exp > EXP_TOP) begin
      data_d   = {res_sign_q, {(W-1){1'b1}}};
      status_d = 4'b1010;
    end else if (fin_exp < EXP_ONE) begin
      data_d   = {res_sign_q, {(W-1){1'b0}}};
      status_d = 4'b0111;
    end else begin
      data_d   = {res_sign_q, fin_exp[EXP_W-1:0], fin_frac};
      status_d = {2'b00, inexact, 1'b0};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      l_sign_q   <= 1'b0;
      sub_q      <= 1'b0;
      res_sign_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      l_exp_q    <= '0;
      exp_diff_q <= '0;
      l_man_q    <= '0;
      s_man_q    <= '0;
      norm_man_q <= '0;
      sum_q      <= '0;
      norm_exp_q <= '0;
      data_q     <= '0;
      status_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fpu_io.start) begin
            l_sign_q   <= l_sign_d;
            sub_q      <= sub_d;
            l_exp_q    <= l_exp_d;
            l_man_q    <= l_man_d;
            s_man_q    <= s_man_d;
            exp_diff_q <= exp_diff_d;
            busy_q     <= 1'b1;
            state_q    <= ALIGN;
          end
        end
        ALIGN: begin
          s_man_q <= align_d;
          state_q <= ADD;
        end
        ADD: begin
          sum_q      <= sum_d;
          res_sign_q <= res_sign_d;
          state_q    <= NORM;
        end
        NORM: begin
          norm_man_q <= norm_man_d;
          norm_exp_q <= norm_exp_d;
          state_q    <= ROUND;
        end
        ROUND: begin
          data_q   <= data_d;
          status_q <= status_d;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fpu_io.busy       = busy_q;
  assign fpu_io.done       = done_q;
  assign fpu_io.data_out   = data_q;
  assign fpu_io.status_out = status_q;
endmodule

// File: tb/tb_fpu_addsub.sv
// tb/tb_fpu_addsub.sv - self-checking bench for fpu_addsub against an exact-arithmetic model
module tb_fpu_addsub;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  fpu_addsub_if #(.W(32)) io ();
  fpu_addsub dut (.clock(clock), .reset(reset), .fpu_io(io));

  always #5 clock = ~clock;

  // Exact sum as a wide integer scaled to the smaller exponent, then rounded to 26 significant bits.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic o,
                                output logic [31:0] res, output logic [3:0] st);
    logic [127:0] ma, mb, mag, keep, rem, half;
    int   ea, eb, emin, p, e;
    logic sa, sb, sr, inx;
    ea = int'(a[30:25]);
    eb = int'(b[30:25]);
    sa = a[31];
    sb = b[31] ^ o;
    ma = '0;
    mb = '0;
    emin = (ea == 0) ? eb : (eb == 0) ? ea : ((ea < eb) ? ea : eb);
    if (ea != 0) ma = {102'd0, 1'b1, a[24:0]} << (ea - emin);
    if (eb != 0) mb = {102'd0, 1'b1, b[24:0]} << (eb - emin);
    if (sa == sb)      begin mag = ma + mb; sr = sa; end
    else if (ma >= mb) begin mag = ma - mb; sr = sa; end
    else               begin mag = mb - ma; sr = sb; end
    if (mag == '0) begin
      res = 32'h0;
      st  = 4'b0001;
      return;
    end
    p = 0;
    for (int i = 0; i < 128; i++) if (mag[i]) p = i;
    e = p + emin - 25;
    if (p > 25) begin
      keep = mag >> (p - 25);
      rem  = mag & ((128'd1 << (p - 25)) - 128'd1);
      half = 128'd1 << (p - 26);
    end else begin
      keep = mag << (25 - p);
      rem  = '0;
      half = '0;
    end
    inx = (rem != '0);
`ifdef FPU_RNE_EN
    if (rem > half || (rem == half && rem != '0 && keep[0])) keep = keep + 128'd1;
`endif
    if (keep[26]) begin
      keep = keep >> 1;
      e    = e + 1;
    end
    if (e > 63)     begin res = {sr, 31'h7FFFFFFF}; st = 4'b1010; end
    else if (e < 1) begin res = {sr, 31'h0};        st = 4'b0111; end
    else            begin res = {sr, e[5:0], keep[24:0]}; st = {2'b00, inx, 1'b0}; end
  endfunction

  // Call at a negedge; returns at the negedge where done is seen (or after a 20-cycle bound).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic o,
                        output logic [31:0] res, output logic [3:0] st, output int cyc);
    io.start   = 1'b1;
    io.op_A_in = a;
    io.op_B_in = b;
    io.op      = o;
    @(posedge clock);
    @(negedge clock);
    io.start   = 1'b0;
    io.op_A_in = $urandom;
    io.op_B_in = $urandom;
    io.op      = 1'($urandom);
    cyc = 0;
    while (!io.done && cyc < 20) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
    end
    res = io.data_out;
    st  = io.status_out;
  endtask

  task automatic test_reset();
    io.start = 1'b0; io.op = 1'b0; io.op_A_in = '0; io.op_B_in = '0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    n_total++; if (io.data_out !== 32'h0) $display("FAIL reset_data got %h expected 00000000", io.data_out); else n_pass++;
    n_total++; if (io.status_out !== 4'h0) $display("FAIL reset_status got %b expected 0000", io.status_out); else n_pass++;
    n_total++; if ({io.busy, io.done} !== 2'b00) $display("FAIL reset_busy_done got %b expected 00", {io.busy, io.done}); else n_pass++;
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_directed();
    logic [31:0] va [10], vb [10], vr [10];
    logic [3:0]  vs [10];
    logic        vo [10];
    logic [31:0] got;
    logic [3:0]  gst;
    int          cyc;
`ifdef FPU_RNE_EN
    logic [31:0] rnd_exp = 32'h3E000002;
`else
    logic [31:0] rnd_exp = 32'h3E000001;
`endif
    va = '{32'h3E000000, 32'h3E000000, 32'h3E000000, 32'h3E000000, 32'h7FFFFFFF,
           32'h02000001, 32'h00000001, 32'hBE000000, 32'h40000000, 32'h3E000000};
    vb = '{32'h3E000000, 32'h3E000000, 32'h40000000, 32'h0D000000, 32'h7FFFFFFF,
           32'h02000000, 32'h3E000000, 32'h3E000000, 32'h3E000000, 32'h40000000};
    vo = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vr = '{32'h40000000, 32'h00000000, 32'h41000000, rnd_exp, 32'h7FFFFFFF,
           32'h00000000, 32'h3E000000, 32'h00000000, 32'h3E000000, 32'hBE000000};
    vs = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b1010,
           4'b0111, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
    for (int k = 0; k < 10; k++) begin
      run_op(va[k], vb[k], vo[k], got, gst, cyc);
      n_total++; if (got !== vr[k]) $display("FAIL directed_data[%0d] got %h expected %h", k, got, vr[k]); else n_pass++;
      n_total++; if (gst !== vs[k]) $display("FAIL directed_status[%0d] got %b expected %b", k, gst, vs[k]); else n_pass++;
      n_total++; if (cyc !== 4) $display("FAIL directed_latency[%0d] got %0d expected 4", k, cyc); else n_pass++;
    end
  endtask

  task automatic test_random(input int n);
    logic [31:0] a, b, got, exp_r;
    logic [3:0]  gst, est;
    logic        o;
    int          cyc, ea, eb;
    for (int k = 0; k < n; k++) begin
      ea = int'($urandom_range(0, 63));
      case ($urandom_range(0, 3))
        0:       eb = int'($urandom_range(0, 63));
        1:       eb = ea + int'($urandom_range(0, 6)) - 3;
        2:       eb = ea;
        default: eb = ea + int'($urandom_range(20, 30)) * (($urandom_range(0, 1) == 1) ? 1 : -1);
      endcase
      if (eb < 0)  eb = 0;
      if (eb > 63) eb = 63;
      a = {1'($urandom), 6'(ea), 25'($urandom)};
      b = {1'($urandom), 6'(eb), 25'($urandom)};
      if (eb == ea && (k % 2) == 0) b[24:0] = a[24:0] ^ 25'($urandom_range(0, 7));
      o = 1'($urandom);
      model(a, b, o, exp_r, est);
      run_op(a, b, o, got, gst, cyc);
      n_total++; if (got !== exp_r) $display("FAIL random_data a=%h b=%h op=%b got %h expected %h", a, b, o, got, exp_r); else n_pass++;
      n_total++; if (gst !== est) $display("FAIL random_status a=%h b=%h op=%b got %b expected %b", a, b, o, gst, est); else n_pass++;
      n_total++; if (cyc !== 4) $display("FAIL random_latency got %0d expected 4", cyc); else n_pass++;
    end
  endtask

  task automatic test_busy_ignore();
    int          ndone = 0, first = -1;
    logic [31:0] seen = '0;
    io.start = 1'b1; io.op = 1'b0; io.op_A_in = 32'h3E000000; io.op_B_in = 32'h3E000000;
    @(posedge clock);
    @(negedge clock);
    io.start = 1'b0;
    n_total++; if (io.busy !== 1'b1) $display("FAIL busy_after_accept got %b expected 1", io.busy); else n_pass++;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clock);
      @(negedge clock);
      io.start = (c == 1);
      io.op_A_in = 32'h7FFFFFFF; io.op_B_in = 32'h7FFFFFFF;
      if (io.done) begin
        ndone++;
        if (first < 0) begin first = c; seen = io.data_out; end
      end
    end
    n_total++; if (ndone !== 1) $display("FAIL busy_ignore_done_count got %0d expected 1", ndone); else n_pass++;
    n_total++; if (first !== 4) $display("FAIL busy_ignore_done_cycle got %0d expected 4", first); else n_pass++;
    n_total++; if (seen !== 32'h40000000) $display("FAIL busy_ignore_data got %h expected 40000000", seen); else n_pass++;
    n_total++; if (io.busy !== 1'b0) $display("FAIL busy_idle got %b expected 0", io.busy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    logic [3:0]  gst;
    int          cyc, ndone = 0;
    run_op(32'h3E000000, 32'h3E000000, 1'b0, got, gst, cyc);
    n_total++; if (got !== 32'h40000000) $display("FAIL pre_reset_data got %h expected 40000000", got); else n_pass++;
    @(negedge clock);
    io.start = 1'b1; io.op = 1'b0; io.op_A_in = 32'h3E000000; io.op_B_in = 32'h40000000;
    @(posedge clock);
    @(negedge clock);
    io.start = 1'b0;
    repeat (2) begin @(posedge clock); @(negedge clock); end
    reset = 1'b0;
    #1;
    n_total++; if (io.data_out !== 32'h0) $display("FAIL midreset_data got %h expected 00000000", io.data_out); else n_pass++;
    n_total++; if ({io.busy, io.done, io.status_out} !== 6'b0) $display("FAIL midreset_flags got %b expected 000000", {io.busy, io.done, io.status_out}); else n_pass++;
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (io.done) ndone++;
    end
    n_total++; if (ndone !== 0) $display("FAIL midreset_no_done got %0d expected 0", ndone); else n_pass++;
    run_op(32'h3E000000, 32'h40000000, 1'b0, got, gst, cyc);
    n_total++; if (got !== 32'h41000000) $display("FAIL post_reset_data got %h expected 41000000", got); else n_pass++;
    n_total++; if (cyc !== 4) $display("FAIL post_reset_latency got %0d expected 4", cyc); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, got, exp_r;
    logic [3:0]  gst, est;
    int          cyc;
    for (int k = 0; k < 6; k++) begin
      a = {1'($urandom), 6'($urandom_range(28, 34)), 25'($urandom)};
      b = {1'($urandom), 6'($urandom_range(28, 34)), 25'($urandom)};
      model(a, b, 1'b1, exp_r, est);
      run_op(a, b, 1'b1, got, gst, cyc);
      n_total++; if ({got, gst} !== {exp_r, est}) $display("FAIL b2b[%0d] got %h/%b expected %h/%b", k, got, gst, exp_r, est); else n_pass++;
      n_total++; if (cyc !== 4) $display("FAIL b2b_latency[%0d] got %0d expected 4", k, cyc); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_random(300);
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/fpu_addsub.md
# fpu_addsub

Parametrised multi-cycle floating-point adder/subtractor for the team's custom sign/exponent/mantissa format: 1 sign bit, `EXP_W` exponent bits and `MAN_W` fraction bits, with the default 6/25 split giving a 32-bit word and bias 31. It generalises the single-mode add datapath with a start/done handshake, subtraction, normalisation, rounding and IEEE-style status flags. It sits between operand registers and the result bus of the FPU, and processes one operation at a time with fixed latency.

## Interface
- `EXP_W`, default 6: exponent field width; `BIAS = 2**(EXP_W-1) - 1`.
- `MAN_W`, default 25: stored fraction width (hidden 1 implied).
- `W`, default `1+EXP_W+MAN_W` (localparam): word width.
- `clock` in 1: rising-edge clock.
- `reset` in 1: reset, asynchronous, active-low.
- `start` in 1: request; sampled only in IDLE.
- `op` in 1: 0 = A+B, 1 = A−B; sampled with `start`.
- `op_A_in` in W: operand A {sign, exp, frac}; sampled with `start`.
- `op_B_in` in W: operand B; sampled with `start`.
- `busy` in→out 1: high from the cycle after accept until `done`.
- `done` out 1: one-cycle pulse; result valid.
- `data_out` out W: result, held until the next `done`.
- `status_out` out 4: {[3] overflow, [2] underflow, [1] inexact, [0] zero}, held with `data_out`.

## Operation
- FSM: IDLE → ALIGN → ADD → NORM → ROUND → IDLE. No other transitions. Reset enters IDLE.
- IDLE, `start`=1: register operands and `op`. Effective B sign = B.sign XOR `op`. Exponent field 0 means zero (denormals flush to zero, frac ignored). The exponent all-ones field is an ordinary number; there is no Inf/NaN.
- Accept:
  - Order operands by magnitude {exp, frac}; the larger magnitude is L.
  - `exp_diff` = L.exp − S.exp, unsigned `EXP_W` bits.
- ALIGN:
  - Form {1, frac, G, R, S} for both operands, `MAN_W+4` bits.
  - Shift S right by `exp_diff`. Bits shifted past S OR into sticky.
  - If shift ≥ `MAN_W+3`, S becomes sticky-only.
- ADD:
  - Signs equal: add magnitudes. Signs differ: L − S, never negative.
  - Width is `MAN_W+5` (carry bit).
  - Result sign = L.sign.
  - Exact zero result gets sign +0.
- NORM:
  - Carry set: shift right 1, keep sticky, exp+1.
  - Otherwise: leading-zero count and single left shift, exp − lzc.
  - Exponent is computed in `EXP_W+2` signed bits.
- ROUND:
  - Apply the rounding mode (see Configuration).
  - Mantissa carry-out after rounding: shift right 1, exp+1.
  - inexact = G|R|S ≠ 0 before rounding.
  - Write outputs, pulse `done`.
- Overflow (final exp > `2**EXP_W − 1`): `data_out` = {sign, all-ones exp, all-ones frac}, overflow=1, inexact=1.
- Underflow (final exp < 1, nonzero result): `data_out` = {sign, 0…}, underflow=1, inexact=1, zero=1.
- zero flag is set whenever `data_out` exp field is 0.

## Timing
- Reset values: `data_out`=0, `status_out`=0, `done`=0, `busy`=0, FSM=IDLE, all internal registers cleared.
- Latency: accepted at edge N; `done`=1 and outputs updated after edge N+4, i.e. 4 cycles start→done.
- `start` while `busy`=1 is ignored; no queueing.
- `start` in the `done` cycle is accepted, since the FSM is already IDLE. Throughput is 1 op / 5 cycles.
- Operand inputs may change freely after the accept edge.
- Reset mid-operation aborts immediately. No `done` is issued, and outputs return to reset values.

## Configuration
- `FPU_RNE_EN` defined: round-to-nearest-even on G/R/S. Round up if G & (R|S|LSB).
- `FPU_RNE_EN` undefined: truncation (round toward zero). G/R/S are dropped.
- inexact behaviour is identical in both builds.

## Test plan
- 0x3E000000 + 0x3E000000 (1.0+1.0), `op`=0 → 0x40000000, status 4'b0000, `done` exactly 4 cycles after `start`.
- 0x3E000000 − 0x3E000000 → 0x00000000, status 4'b0001. Separately, 0x3E000000 + 0x40000000 → 0x41000000 (3.0).
- 0x3E000000 + 0x0D000000 (1 + 1.5 ulp) → `FPU_RNE_EN`: 0x3E000002; without: 0x3E000001; status 4'b0010 in both builds.
- 0x7FFFFFFF + 0x7FFFFFFF → 0x7FFFFFFF, status 4'b1010.
- 0x02000001 − 0x02000000 → 0x00000000, status 4'b0111. Denormal 0x00000001 + 0x3E000000 → 0x3E000000, status 4'b0000.
- Pulse `start` again 2 cycles after accept → ignored, single `done`. Assert `reset` during NORM → `done` never pulses, outputs 0; the next `start` completes normally.
